// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer: arbitration mode encodings
// and the output-stage state type.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/chan_arb.sv
// Combinational channel arbiter: fixed priority (lowest index) or round-robin
// search starting at ptr, wrapping explicitly at N_CH.
module chan_arb
  import chan_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            mode,
  output logic [N_CH-1:0] gnt_onehot,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    logic [CH_W:0]   w_sum;
    logic [CH_W-1:0] w_idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < N_CH; k++) begin
      // ptr < N_CH and k < N_CH, so one subtraction is enough to wrap.
      w_sum = (CH_W+1)'(k);
      if (mode == MODE_RR) w_sum = {1'b0, ptr} + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(N_CH)) w_sum = w_sum - (CH_W+1)'(N_CH);
      w_idx = w_sum[CH_W-1:0];
      if (!gnt_any && req[w_idx]) begin
        gnt_any           = 1'b1;
        gnt_idx           = w_idx;
        gnt_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux_arb.sv
// N-channel valid/ready multiplexer with run-time selectable arbitration and a
// single-entry registered output stage sustaining one word per cycle.
module chan_mux_arb
  import chan_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_chan,
  input  logic                  out_ready
);

  // Handshake rule on every port: a word moves on a rising edge where valid
  // and ready are both high; valid never waits on ready.
  out_state_e        r_state;
  out_state_e        w_state_nxt;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [WIDTH-1:0]  r_data;
  logic [CH_W-1:0]   r_chan;
  logic [N_CH-1:0]   w_gnt_onehot;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_gnt_any;
  logic              w_can_load;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_sel_data;

  chan_arb #(.N_CH(N_CH)) u_arb (
    .req        (in_valid),
    .ptr        (r_rr_ptr),
    .mode       (mode),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .gnt_any    (w_gnt_any)
  );

  assign w_can_load = (r_state == ST_EMPTY) || out_ready;
  assign w_xfer     = w_can_load && w_gnt_any;
  assign in_ready   = (rst || !w_can_load) ? '0 : w_gnt_onehot;
  assign w_sel_data = in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer)                              w_state_nxt = ST_FULL;
    else if (r_state == ST_FULL && out_ready) w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Data and channel tag only change on a load so a drained word stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_chan   <= '0;
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_data <= w_sel_data;
      r_chan <= w_gnt_idx;
      if (mode == MODE_RR)
        r_rr_ptr <= (w_gnt_idx == CH_W'(N_CH-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_chan_mux_arb.sv
// Bench for chan_mux_arb (N_CH=4, WIDTH=8): directed vector table, random
// traffic against a reference model, and asynchronous reset checks.
module tb_chan_mux_arb;

  localparam int N = 4;
  localparam int W = 8;
  localparam logic [31:0] DA = 32'h4332_2110;
  localparam logic [31:0] DB = 32'h43A5_2110;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_chan;
  logic         out_ready;

  always #5 clk = ~clk;

  chan_mux_arb #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        md;
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  oc;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           sb_en    = 1'b0;

  // Reference model state: the output register contents and the RR pointer.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  // Advances the model by one clock; returns the in_ready expected before it.
  task automatic model_step(input logic md, input logic [3:0] v, input logic [31:0] d,
                            input logic ordy, output logic [3:0] e_rdy);
    int g = -1;
    bit can_load;
    for (int k = 0; k < N; k++) begin
      int c;
      c = md ? (m_ptr + k) % N : k;
      if (g < 0 && v[c]) g = c;
    end
    can_load = !m_valid || ordy;
    e_rdy = '0;
    if (can_load && g >= 0) begin
      e_rdy[g] = 1'b1;
      m_valid  = 1'b1;
      m_data   = d[g*W +: W];
      m_chan   = g;
      if (md) m_ptr = (g + 1) % N;
      if (sb_en) exp_q.push_back(d[g*W +: W]);
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_cycle(input logic md, input logic [3:0] v, input logic [31:0] d,
                          input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                          input logic [7:0] e_od, input logic [1:0] e_oc, input string tag);
    @(negedge clk);
    mode = md; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(e_rdy));
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_word: got 0x%0h with no word expected", out_data);
      end else begin
        chk("sb_word", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, " out_data"},  32'(out_data),  32'(e_od));
    chk({tag, " out_chan"},  32'(out_chan),  32'(e_oc));
  endtask

  initial begin
    logic [3:0]  e_rdy;
    logic        r_md, r_ordy;
    logic [3:0]  r_v;
    logic [31:0] r_d;

    rst = 1'b1; mode = 1'b0; in_valid = 4'hF; in_data = DA; out_ready = 1'b0;
    model_reset();
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data",  32'(out_data),  32'd0);
    chk("reset out_chan",  32'(out_chan),  32'd0);
    chk("reset in_ready",  32'(in_ready),  32'd0);
    in_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    // Fixed priority, all valid
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
    // Round-robin fairness
    tbl.push_back('{1'b1, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{1'b1, 4'hF, DA, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1});
    tbl.push_back('{1'b1, 4'hF, DA, 1'b1, 4'b0100, 1'b1, 8'h32, 2'd2});
    tbl.push_back('{1'b1, 4'hF, DA, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3});
    tbl.push_back('{1'b1, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{1'b1, 4'hF, DA, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1});
    // RR skip with pointer at 2, only ch0/ch3 requesting
    tbl.push_back('{1'b1, 4'h9, DA, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3});
    tbl.push_back('{1'b1, 4'h9, DA, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{1'b1, 4'h9, DA, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3});
    // Backpressure on 0xA5 from ch2, then zero-bubble reload
    tbl.push_back('{1'b0, 4'h4, DB, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 4'hF, DB, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2});
    tbl.push_back('{1'b0, 4'hF, DB, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
    // Drain: valid drops, data and channel hold
    tbl.push_back('{1'b0, 4'h0, DB, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0});
    tbl.push_back('{1'b0, 4'h0, DB, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0});
    // Mode switch with pointer at 3; pointer must survive fixed-mode grant
    tbl.push_back('{1'b1, 4'h4, DB, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2});
    tbl.push_back('{1'b0, 4'hA, DA, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1});
    tbl.push_back('{1'b1, 4'hA, DA, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3});
    tbl.push_back('{1'b1, 4'h0, DA, 1'b0, 4'b0000, 1'b1, 8'h43, 2'd3});
    tbl.push_back('{1'b1, 4'h0, DA, 1'b1, 4'b0000, 1'b0, 8'h43, 2'd3});

    foreach (tbl[i]) begin
      model_step(tbl[i].md, tbl[i].v, tbl[i].d, tbl[i].ordy, e_rdy);
      do_cycle(tbl[i].md, tbl[i].v, tbl[i].d, tbl[i].ordy,
               tbl[i].rdy, tbl[i].ov, tbl[i].od, tbl[i].oc, $sformatf("vec%0d", i));
    end

    // Random traffic against the model, with word-order scoreboard
    sb_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r_md   = 1'($urandom_range(0, 1));
      r_v    = 4'($urandom_range(0, 15));
      r_d    = $urandom;
      r_ordy = ($urandom_range(0, 3) != 0);
      model_step(r_md, r_v, r_d, r_ordy, e_rdy);
      do_cycle(r_md, r_v, r_d, r_ordy, e_rdy, m_valid, m_data, 2'(m_chan), "rand");
    end
    model_step(1'b0, 4'h0, DA, 1'b1, e_rdy);
    do_cycle(1'b0, 4'h0, DA, 1'b1, e_rdy, m_valid, m_data, 2'(m_chan), "rand_drain");
    chk("sb_left_over", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b0;

    // Asynchronous reset with a word held in the output register
    model_step(1'b1, 4'hF, DB, 1'b1, e_rdy);
    do_cycle(1'b1, 4'hF, DB, 1'b1, e_rdy, m_valid, m_data, 2'(m_chan), "pre_rst");
    @(negedge clk);
    in_valid = 4'hF; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data",  32'(out_data),  32'd0);
    chk("midrst out_chan",  32'(out_chan),  32'd0);
    chk("midrst in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    in_valid = 4'h0;
    rst = 1'b0;
    model_reset();
    model_step(1'b1, 4'hF, DA, 1'b1, e_rdy);
    do_cycle(1'b1, 4'hF, DA, 1'b1, e_rdy, m_valid, m_data, 2'(m_chan), "post_rst");
    model_step(1'b1, 4'hF, DA, 1'b1, e_rdy);
    do_cycle(1'b1, 4'hF, DA, 1'b1, e_rdy, m_valid, m_data, 2'(m_chan), "post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
